// File: rtl/booth_arb_pkg.sv
// Shared types and timing constants for the Booth multiplier arbiter.
package booth_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    // Cycles the attached sequential multiplier stays busy after mul_start.
    localparam int MUL_CYCLES     = 8;
    localparam int TIMEOUT_CYCLES = 12;

endpackage

// File: rtl/booth_mul_arbiter_if.sv
// Requester-side bus of the multiplier arbiter: per-requester operation and result handshakes.
interface booth_mul_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_mc;
    logic [NREQ*WIDTH-1:0] req_mp;
    logic [NREQ-1:0]       resp_valid;
    logic [NREQ-1:0]       resp_ready;
    logic [2*WIDTH-1:0]    resp_prod;
    logic                  resp_err;

    modport master (
        output req_valid, req_mc, req_mp, resp_ready,
        input  req_ready, resp_valid, resp_prod, resp_err
    );

    modport slave (
        input  req_valid, req_mc, req_mp, resp_ready,
        output req_ready, resp_valid, resp_prod, resp_err
    );
endinterface

// File: rtl/booth_rr_pick.sv
// Combinational rotate-priority picker: the requester just after 'last' has highest priority,
// 'last' itself the lowest.
module booth_rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] idx
);
    localparam int IDXW = $clog2(NREQ);

    logic [IDXW-1:0] pos;

    // Walk from lowest to highest priority so the nearest requester overwrites earlier hits.
    always_comb begin
        grant = '0;
        idx   = '0;
        pos   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            pos = IDXW'((int'(last) + k) % NREQ);
            if (req[pos]) begin
                grant      = '0;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end
endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one sequential Booth multiplier among NREQ requesters.
// Define BOOTH_ARB_TIMEOUT_EN to abandon a stuck multiplier after TIMEOUT_CYCLES with resp_err.
module booth_mul_arbiter
    import booth_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    booth_mul_arbiter_if.slave bus,
    output logic               mul_start,
    output logic [WIDTH-1:0]   mul_mc,
    output logic [WIDTH-1:0]   mul_mp,
    input  logic [2*WIDTH-1:0] mul_prod,
    input  logic               mul_busy
);
    // state | meaning
    // IDLE  | offer req_ready to the round-robin pick, latch operands on handshake
    // START | one-cycle mul_start, mul_busy ignored
    // WAIT  | capture mul_prod on the first cycle mul_busy is low
    // RESP  | resp_valid[owner] until resp_ready[owner]

    localparam int IDXW = $clog2(NREQ);

    arb_state_t         state;
    arb_state_t         state_nxt;
    logic [IDXW-1:0]    owner;
    logic [IDXW-1:0]    last_owner;
    logic [IDXW-1:0]    pick_idx;
    logic [NREQ-1:0]    pick_grant;
    logic [WIDTH-1:0]   mc_arr [NREQ];
    logic [WIDTH-1:0]   mp_arr [NREQ];
    logic [2*WIDTH-1:0] prod_q;
    logic               accept;
    logic               capture;
    logic               resp_done;
    logic               timeout;

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign mc_arr[g] = bus.req_mc[g*WIDTH +: WIDTH];
        assign mp_arr[g] = bus.req_mp[g*WIDTH +: WIDTH];
    end

    booth_rr_pick #(
        .NREQ(NREQ)
    ) u_pick (
        .req  (bus.req_valid),
        .last (last_owner),
        .grant(pick_grant),
        .idx  (pick_idx)
    );

    assign accept    = (state == ST_IDLE) && (|bus.req_valid);
    assign capture   = (state == ST_WAIT) && !mul_busy;
    assign resp_done = (state == ST_RESP) && bus.resp_ready[owner];

    // Handshake outputs are masked during reset so no requester sees a grant or result
    // that the arbiter is about to discard.
    assign bus.req_ready  = (state == ST_IDLE && !rst) ? pick_grant : '0;
    assign bus.resp_valid = (state == ST_RESP && !rst) ? (NREQ'(1) << owner) : '0;
    assign bus.resp_prod  = prod_q;
    assign mul_start      = (state == ST_START);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_START;
            ST_START: state_nxt = ST_WAIT;
            ST_WAIT:  if (capture || timeout) state_nxt = ST_RESP;
            ST_RESP:  if (resp_done) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_owner <= IDXW'(NREQ - 1);
            owner      <= '0;
            mul_mc     <= '0;
            mul_mp     <= '0;
            prod_q     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner  <= pick_idx;
                mul_mc <= mc_arr[pick_idx];
                mul_mp <= mp_arr[pick_idx];
            end
            if (capture) begin
                prod_q <= mul_prod;
            end else if (timeout) begin
                prod_q <= '0;
            end
            if (resp_done) begin
                last_owner <= owner;
            end
        end
    end

`ifdef BOOTH_ARB_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES);

    logic [TCW-1:0] tmo_cnt;
    logic           err_q;

    // Terminal count reached on the last allowed WAIT cycle while still busy.
    assign timeout = (state == ST_WAIT) && mul_busy && (tmo_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == ST_START) begin
                tmo_cnt <= TCW'(TIMEOUT_CYCLES - 1);
            end else if (state == ST_WAIT && tmo_cnt != '0) begin
                tmo_cnt <= tmo_cnt - 1'b1;
            end
            if (capture || resp_done) begin
                err_q <= 1'b0;
            end else if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.resp_err = err_q;
`else
    assign timeout      = 1'b0;
    assign bus.resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Self-checking bench for booth_mul_arbiter with a behavioural 8-cycle multiplier alongside.
module tb_booth_mul_arbiter;
    import booth_arb_pkg::*;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 8;
    localparam int BOUND   = 80;
    localparam int EXP_LAT = MUL_CYCLES + 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               mul_start;
    logic               mul_busy;
    logic [WIDTH-1:0]   mul_mc;
    logic [WIDTH-1:0]   mul_mp;
    logic [2*WIDTH-1:0] mul_prod;

    booth_mul_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    booth_mul_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .mul_start(mul_start),
        .mul_mc   (mul_mc),
        .mul_mp   (mul_mp),
        .mul_prod (mul_prod),
        .mul_busy (mul_busy)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
        int ia, ib;
        ia = int'($signed(a));
        ib = int'($signed(b));
        return 16'(ia * ib);
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int rr_expect(input logic [NREQ-1:0] pend, input int last);
        for (int k = 1; k <= NREQ; k++)
            if (pend[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    // Multiplier model: busy for MUL_CYCLES after start, product shown for one cycle, then 0.
    int m_cnt      = 0;
    bit m_active   = 1'b0;
    bit stuck_busy = 1'b0;

    always @(posedge clk) begin
        if (mul_start) begin
            m_cnt    <= MUL_CYCLES;
            m_active <= 1'b1;
        end else if (m_active && !stuck_busy) begin
            if (m_cnt != 0) m_cnt <= m_cnt - 1;
            else            m_active <= 1'b0;
        end
    end

    assign mul_busy = stuck_busy || (m_active && m_cnt != 0);
    assign mul_prod = (m_active && m_cnt == 0 && !stuck_busy) ? smul(mul_mc, mul_mp) : '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: no event within %0d cycles, expected one", name, BOUND);
    endtask

    task automatic set_ops(input int i, input logic [7:0] mc, input logic [7:0] mp);
        bus.req_mc[i*WIDTH +: WIDTH] = mc;
        bus.req_mp[i*WIDTH +: WIDTH] = mp;
    endtask

    // Entered with this frame's inputs driven just after a negedge; returns in the IDLE frame
    // following the response handshake.
    task automatic serve(input bit drop, input int hold, output int who, output int wait_cyc,
                         output int lat, output logic [15:0] prod, output logic err);
        int starts, start_at;
        bit unstable;
        who = -1; wait_cyc = 0; lat = 0; prod = '0; err = 1'b0;
        starts = 0; start_at = -1; unstable = 1'b0;
        #1;
        while (bus.req_ready == '0 && wait_cyc < BOUND) begin
            @(negedge clk); #1; wait_cyc++;
        end
        if (bus.req_ready == '0) begin bound_fail("grant_wait"); return; end
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) who = i;
        check("ready_onehot", $countones(bus.req_ready), 1);
        check("ready_has_valid", bus.req_valid[who], 1);
        while (lat == 0 || (bus.resp_valid == '0 && lat < BOUND)) begin
            @(negedge clk);
            if (lat == 0 && drop) bus.req_valid[who] = 1'b0;
            bus.resp_ready = ~onehot(who);
            #1; lat++;
            if (mul_start) begin starts++; start_at = lat; end
            if (bus.req_ready != '0) unstable = 1'b1;
        end
        if (bus.resp_valid == '0) begin bound_fail("resp_wait"); return; end
        check("start_pulse", {32'(starts), 32'(start_at)}, {32'd1, 32'd1});
        check("resp_onehot", bus.resp_valid, onehot(who));
        prod = bus.resp_prod;
        err  = bus.resp_err;
        for (int h = 1; h < hold; h++) begin
            @(negedge clk); #1;
            if (bus.resp_valid != onehot(who) || bus.resp_prod != prod ||
                bus.resp_err != err || bus.req_ready != '0) unstable = 1'b1;
        end
        @(negedge clk);
        bus.resp_ready = onehot(who);
        #1;
        if (bus.resp_valid != onehot(who) || bus.resp_prod != prod) unstable = 1'b1;
        check("hold_stable", unstable, 0);
        @(negedge clk);
        bus.resp_ready = '0;
        #1;
        check("idle_after_resp", bus.resp_valid, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid  = '0;
        bus.resp_ready = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        int          who;
        logic [7:0]  mc;
        logic [7:0]  mp;
        int          hold;
        logic [15:0] prod;
    } vec_t;

    vec_t            vecs[8];
    int              who, wt, lat, ref_last, exp_who;
    logic [15:0]     prod, exp_prod;
    logic            err;
    logic [NREQ-1:0] pend;
    logic [7:0]      rmc[NREQ];
    logic [7:0]      rmp[NREQ];
    bit              quiet;
    int              order[5];

    initial begin
        vecs[0] = '{0, 8'h03, 8'hFE, 1, 16'hFFFA};
        vecs[1] = '{2, 8'h7F, 8'h7F, 2, 16'h3F01};
        vecs[2] = '{3, 8'h80, 8'h80, 1, 16'h4000};
        vecs[3] = '{1, 8'h80, 8'h7F, 3, 16'hC080};
        vecs[4] = '{0, 8'hFF, 8'hFF, 1, 16'h0001};
        vecs[5] = '{2, 8'h00, 8'h5A, 2, 16'h0000};
        vecs[6] = '{3, 8'hFB, 8'h05, 1, 16'hFFE7};
        vecs[7] = '{1, 8'hFF, 8'h80, 1, 16'h0080};
        order   = '{0, 1, 2, 3, 0};

        rst = 1'b1;
        bus.req_valid  = '1;
        bus.req_mc     = '0;
        bus.req_mp     = '0;
        bus.resp_ready = '0;
        repeat (3) @(negedge clk);
        #1 check("reset_outputs", {bus.req_ready, bus.resp_valid, bus.resp_err, mul_start,
                                   mul_mc, mul_mp, bus.resp_prod}, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = '0;
        #1 check("post_reset_idle", {bus.req_ready, bus.resp_valid, bus.resp_err, mul_start}, 0);
        ref_last = NREQ - 1;

        // Table vectors, single requester each; the first one is the post-reset example.
        foreach (vecs[i]) begin
            @(negedge clk);
            set_ops(vecs[i].who, vecs[i].mc, vecs[i].mp);
            bus.req_valid = onehot(vecs[i].who);
            serve(1'b1, vecs[i].hold, who, wt, lat, prod, err);
            check($sformatf("tbl%0d_who", i), who, vecs[i].who);
            check($sformatf("tbl%0d_lat", i), lat, EXP_LAT);
            check($sformatf("tbl%0d_prod", i), prod, vecs[i].prod);
            check($sformatf("tbl%0d_err", i), err, 0);
        end

        // Two requesters after reset: req0 first, req1 granted in the next IDLE cycle.
        do_reset();
        set_ops(0, 8'h12, 8'h34);
        set_ops(1, 8'hF0, 8'h10);
        bus.req_valid = 4'b0011;
        serve(1'b1, 1, who, wt, lat, prod, err);
        check("pair_first_who", who, 0);
        check("pair_first_prod", prod, 16'h03A8);
        serve(1'b1, 1, who, wt, lat, prod, err);
        check("pair_second_who", who, 1);
        check("pair_second_wait", wt, 0);
        check("pair_second_prod", prod, 16'hFF00);

        // Held response for 5 cycles.
        @(negedge clk);
        set_ops(1, 8'h7F, 8'h7F);
        bus.req_valid = 4'b0010;
        serve(1'b1, 5, who, wt, lat, prod, err);
        check("hold5_who", who, 1);
        check("hold5_prod", prod, 16'h3F01);

        // All four requesting continuously.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_ops(i, 8'(i + 1), 8'hFD);
        bus.req_valid = '1;
        for (int n = 0; n < 5; n++) begin
            serve(1'b0, 1, who, wt, lat, prod, err);
            check($sformatf("rr%0d_who", n), who, order[n]);
            check($sformatf("rr%0d_wait", n), wt, 0);
            check($sformatf("rr%0d_prod", n), prod, smul(8'(order[n] + 1), 8'hFD));
        end
        bus.req_valid = '0;

        // Reset during WAIT abandons the operation.
        @(negedge clk);
        set_ops(2, 8'h11, 8'h22);
        bus.req_valid = 4'b0100;
        #1 check("midrst_grant", bus.req_ready, 4'b0100);
        @(negedge clk);
        bus.req_valid = '0;
        repeat (3) @(negedge clk);
        #1 check("midrst_in_wait_busy", mul_busy, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 check("midrst_idle_outputs", {bus.req_ready, bus.resp_valid, bus.resp_err, mul_start,
                                         mul_mc, mul_mp, bus.resp_prod}, 0);
        quiet = 1'b1;
        repeat (15) begin
            @(negedge clk); #1;
            if (bus.resp_valid != '0 || mul_start) quiet = 1'b0;
        end
        check("midrst_abandoned", quiet, 1);
        @(negedge clk);
        set_ops(3, 8'hFB, 8'h05);
        bus.req_valid = 4'b1000;
        serve(1'b1, 1, who, wt, lat, prod, err);
        check("midrst_next_who", who, 3);
        check("midrst_next_lat", lat, EXP_LAT);
        check("midrst_next_prod", prod, 16'hFFE7);
        ref_last = 3;

        // Multiplier stuck busy.
        @(negedge clk);
        stuck_busy = 1'b1;
        set_ops(0, 8'h21, 8'h02);
        bus.req_valid = 4'b0001;
`ifdef BOOTH_ARB_TIMEOUT_EN
        serve(1'b1, 1, who, wt, lat, prod, err);
        stuck_busy = 1'b0;
        check("tmo_lat", lat, TIMEOUT_CYCLES + 2);
        check("tmo_prod", prod, 0);
        check("tmo_err", err, 1);
`else
        fork
            begin
                repeat (30) @(negedge clk);
                stuck_busy = 1'b0;
            end
        join_none
        serve(1'b1, 1, who, wt, lat, prod, err);
        check("stuck_waits", lat > 30, 1);
        check("stuck_prod", prod, 16'h0042);
        check("stuck_err", err, 0);
`endif
        ref_last = 0;

        // Randomized request patterns against the round-robin / signed-product reference.
        for (int n = 0; n < 24; n++) begin
            pend = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                rmc[i] = 8'($urandom);
                rmp[i] = 8'($urandom);
                set_ops(i, rmc[i], rmp[i]);
            end
            exp_who  = rr_expect(pend, ref_last);
            exp_prod = smul(rmc[exp_who], rmp[exp_who]);
            bus.req_valid = pend;
            serve(1'b1, int'($urandom_range(1, 3)), who, wt, lat, prod, err);
            bus.req_valid = '0;
            check($sformatf("rnd%0d_who", n), who, exp_who);
            check($sformatf("rnd%0d_lat", n), lat, EXP_LAT);
            check($sformatf("rnd%0d_prod", n), prod, exp_prod);
            check($sformatf("rnd%0d_err", n), err, 0);
            ref_last = exp_who;
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
